// File: rtl/lpc_mailbox_pkg.sv
// Shared definitions for the LPC byte mailbox: register offsets relative to
// BASE_ADDR, STATUS bit positions and the transaction FSM state encoding.
package lpc_mailbox_pkg;

  localparam logic [1:0] LPC_MBOX_REG_DATA   = 2'd0;
  localparam logic [1:0] LPC_MBOX_REG_STATUS = 2'd1;
  localparam logic [1:0] LPC_MBOX_REG_IEN    = 2'd2;
  localparam logic [1:0] LPC_MBOX_REG_IRQVEC = 2'd3;

  localparam int STAT_D2H_NE   = 0;  // D2H not empty
  localparam int STAT_H2D_FULL = 1;  // H2D full
  localparam int STAT_H2D_OVF  = 2;  // H2D overflow, sticky, W1C
  localparam int STAT_D2H_UNF  = 3;  // D2H underflow, sticky, W1C

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_EXEC = 3'd1,
    ST_WR_ACK  = 3'd2,
    ST_RD_EXEC = 3'd3,
    ST_RD_ACK  = 3'd4
  } state_t;

endpackage

// File: rtl/lpc_mbox_fifo.sv
// Synchronous byte FIFO.
// Ports: clk_i/nrst_i (async active-low reset), push/din, pop/dout,
// full, empty, count. Push when full and pop when empty are ignored, so
// callers may present requests unconditionally. dout reads 0 while empty.
module lpc_mbox_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     nrst_i,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push, do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = empty ? 8'h00 : mem[rd_ptr];

  // Pointers are exactly AW bits wide, so wrap is implicit (DEPTH is 2^AW).
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/lpc_mailbox.sv
// LPC I/O-mapped byte mailbox: four ports at BASE_ADDR (DATA, STATUS, IEN,
// IRQVEC) backed by a host-to-device and a device-to-host FIFO.
// Ports: clk_i, nrst_i (async active-low); LPC front-end handshake
// (lpc_addr_i, lpc_data_i, lpc_data_wr_i/lpc_wr_done_o,
// lpc_data_req_i/lpc_data_rd_o, lpc_data_o); SERIRQ (irq_num_o, interrupt_o);
// local H2D drain (h2d_data_o/h2d_valid_o/h2d_ready_i) and D2H fill
// (d2h_data_i/d2h_valid_i/d2h_ready_o).
// Macro LPC_MAILBOX_IRQ_EN: enables IEN/IRQVEC and the interrupt outputs;
// when undefined those registers read 0, ignore writes, and the interrupt
// outputs are tied low.
module lpc_mailbox
  import lpc_mailbox_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'h0CA8,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        clk_i,
  input  logic        nrst_i,
  input  logic [15:0] lpc_addr_i,
  input  logic [7:0]  lpc_data_i,
  input  logic        lpc_data_wr_i,
  output logic        lpc_wr_done_o,
  input  logic        lpc_data_req_i,
  output logic        lpc_data_rd_o,
  output logic [7:0]  lpc_data_o,
  output logic [3:0]  irq_num_o,
  output logic        interrupt_o,
  output logic [7:0]  h2d_data_o,
  output logic        h2d_valid_o,
  input  logic        h2d_ready_i,
  input  logic [7:0]  d2h_data_i,
  input  logic        d2h_valid_i,
  output logic        d2h_ready_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t        state;
  logic [15:0]   offs;
  logic          hit;
  logic [1:0]    reg_sel;
  logic          wr_exec, rd_exec;
  logic          h2d_full, h2d_empty, d2h_full, d2h_empty;
  logic [7:0]    d2h_head;
  logic [CW-1:0] h2d_cnt, d2h_cnt;
  logic          ovf, unf;
  logic [1:0]    ien;
  logic [3:0]    irqvec;
  logic [7:0]    status, rdata;

  // Subtracting the base handles any BASE_ADDR alignment.
  assign offs    = lpc_addr_i - BASE_ADDR;
  assign hit     = (offs[15:2] == 14'd0);
  assign reg_sel = offs[1:0];
  assign wr_exec = (state == ST_WR_EXEC);
  assign rd_exec = (state == ST_RD_EXEC);

  logic wr_data, rd_data, wr_status;
  assign wr_data   = wr_exec & hit & (reg_sel == LPC_MBOX_REG_DATA);
  assign wr_status = wr_exec & hit & (reg_sel == LPC_MBOX_REG_STATUS);
  assign rd_data   = rd_exec & hit & (reg_sel == LPC_MBOX_REG_DATA);

  // Host push is gated on the current full flag so a same-cycle local pop
  // cannot rescue a byte written into a full FIFO.
  lpc_mbox_fifo #(.DEPTH(FIFO_DEPTH)) u_h2d (
    .clk_i (clk_i), .nrst_i (nrst_i),
    .push  (wr_data & ~h2d_full), .din (lpc_data_i),
    .pop   (h2d_ready_i), .dout (h2d_data_o),
    .full  (h2d_full), .empty (h2d_empty), .count (h2d_cnt)
  );

  lpc_mbox_fifo #(.DEPTH(FIFO_DEPTH)) u_d2h (
    .clk_i (clk_i), .nrst_i (nrst_i),
    .push  (d2h_valid_i), .din (d2h_data_i),
    .pop   (rd_data), .dout (d2h_head),
    .full  (d2h_full), .empty (d2h_empty), .count (d2h_cnt)
  );

  assign h2d_valid_o = ~h2d_empty;
  assign d2h_ready_o = ~d2h_full;

  // Sticky error flags; set wins nothing here since a single transaction
  // cannot both set and clear in one cycle.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (wr_data && h2d_full)                        ovf <= 1'b1;
      else if (wr_status && lpc_data_i[STAT_H2D_OVF]) ovf <= 1'b0;
      if (rd_data && d2h_empty)                       unf <= 1'b1;
      else if (wr_status && lpc_data_i[STAT_D2H_UNF]) unf <= 1'b0;
    end
  end

`ifdef LPC_MAILBOX_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      ien    <= '0;
      irqvec <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (wr_exec && hit && reg_sel == LPC_MBOX_REG_IEN)    ien    <= lpc_data_i[1:0];
      if (wr_exec && hit && reg_sel == LPC_MBOX_REG_IRQVEC) irqvec <= lpc_data_i[3:0];
      irq_q <= (ien[0] & ~d2h_empty) | (ien[1] & ~h2d_full);
    end
  end
  assign interrupt_o = irq_q;
  assign irq_num_o   = irqvec;
`else
  assign ien         = '0;
  assign irqvec      = '0;
  assign interrupt_o = 1'b0;
  assign irq_num_o   = 4'h0;
`endif

  always_comb begin
    status                = 8'h00;
    status[STAT_D2H_NE]   = ~d2h_empty;
    status[STAT_H2D_FULL] = h2d_full;
    status[STAT_H2D_OVF]  = ovf;
    status[STAT_D2H_UNF]  = unf;
  end

  // d2h_head is already 8'h00 when empty, which is the underflow read value.
  always_comb begin
    rdata = 8'hFF;
    if (hit) begin
      case (reg_sel)
        LPC_MBOX_REG_DATA:   rdata = d2h_head;
        LPC_MBOX_REG_STATUS: rdata = status;
        LPC_MBOX_REG_IEN:    rdata = {6'b0, ien};
        default:             rdata = {4'b0, irqvec};
      endcase
    end
  end

  // EXEC performs the side effect unconditionally; if the front-end has
  // already dropped its request the ack is skipped and we return to IDLE.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state         <= ST_IDLE;
      lpc_wr_done_o <= 1'b0;
      lpc_data_rd_o <= 1'b0;
      lpc_data_o    <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (lpc_data_wr_i)       state <= ST_WR_EXEC;
          else if (lpc_data_req_i) state <= ST_RD_EXEC;
        end
        ST_WR_EXEC: begin
          if (lpc_data_wr_i) begin
            state         <= ST_WR_ACK;
            lpc_wr_done_o <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WR_ACK: begin
          if (!lpc_data_wr_i) begin
            state         <= ST_IDLE;
            lpc_wr_done_o <= 1'b0;
          end
        end
        ST_RD_EXEC: begin
          lpc_data_o <= rdata;
          if (lpc_data_req_i) begin
            state         <= ST_RD_ACK;
            lpc_data_rd_o <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RD_ACK: begin
          if (!lpc_data_req_i) begin
            state         <= ST_IDLE;
            lpc_data_rd_o <= 1'b0;
          end
        end
        default: begin
          state         <= ST_IDLE;
          lpc_wr_done_o <= 1'b0;
          lpc_data_rd_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lpc_mailbox.sv
// Scoreboard bench for lpc_mailbox. Host reads push their expected byte
// into exp_q; host writes to DATA append to the model H2D queue. A monitor
// on the falling clock edge pops and compares whenever the DUT presents read
// data or a local H2D pop. The model is plain queues plus flag variables.
module tb_lpc_mailbox;

  localparam logic [15:0] BASE  = 16'h0CA8;
  localparam int          DEPTH = 16;

  logic        clk_i = 1'b0;
  logic        nrst_i = 1'b0;
  logic [15:0] lpc_addr_i = '0;
  logic [7:0]  lpc_data_i = '0;
  logic        lpc_data_wr_i = 1'b0;
  logic        lpc_wr_done_o;
  logic        lpc_data_req_i = 1'b0;
  logic        lpc_data_rd_o;
  logic [7:0]  lpc_data_o;
  logic [3:0]  irq_num_o;
  logic        interrupt_o;
  logic [7:0]  h2d_data_o;
  logic        h2d_valid_o;
  logic        h2d_ready_i = 1'b0;
  logic [7:0]  d2h_data_i = '0;
  logic        d2h_valid_i = 1'b0;
  logic        d2h_ready_o;

  lpc_mailbox #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .nrst_i(nrst_i),
    .lpc_addr_i(lpc_addr_i), .lpc_data_i(lpc_data_i),
    .lpc_data_wr_i(lpc_data_wr_i), .lpc_wr_done_o(lpc_wr_done_o),
    .lpc_data_req_i(lpc_data_req_i), .lpc_data_rd_o(lpc_data_rd_o),
    .lpc_data_o(lpc_data_o), .irq_num_o(irq_num_o), .interrupt_o(interrupt_o),
    .h2d_data_o(h2d_data_o), .h2d_valid_o(h2d_valid_o), .h2d_ready_i(h2d_ready_i),
    .d2h_data_i(d2h_data_i), .d2h_valid_i(d2h_valid_i), .d2h_ready_o(d2h_ready_o)
  );

  always #5 clk_i = ~clk_i;

  // reference model
  logic [7:0] h2d_q[$];
  logic [7:0] d2h_q[$];
  logic [7:0] exp_q[$];
  logic       ovf = 1'b0, unf = 1'b0;
  logic [1:0] ien = '0;
  logic [3:0] ivec = '0;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: compares whatever the DUT presents against the scoreboard
  logic       rd_prev = 1'b0;
  logic [7:0] mon_e;
  always @(negedge clk_i) begin
    if (nrst_i) begin
      if (h2d_ready_i && h2d_valid_o) begin
        if (h2d_q.size() == 0) chk("h2d_unexpected_pop", 1, 0);
        else begin
          mon_e = h2d_q.pop_front();
          chk("h2d_data", h2d_data_o, mon_e);
        end
      end
      if (lpc_data_rd_o && !rd_prev) begin
        if (exp_q.size() == 0) chk("rd_unexpected", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("rd_data", lpc_data_o, mon_e);
        end
      end
    end
    rd_prev = lpc_data_rd_o;
  end

  task automatic host_write(input logic [15:0] a, input logic [7:0] d, input int hold);
    logic [15:0] off;
    off = a - BASE;
    @(posedge clk_i); #1;
    lpc_addr_i = a; lpc_data_i = d; lpc_data_wr_i = 1'b1;
    if (off == 16'd0) begin
      if (h2d_q.size() < DEPTH) h2d_q.push_back(d);
      else ovf = 1'b1;
    end else if (off == 16'd1) begin
      if (d[2]) ovf = 1'b0;
      if (d[3]) unf = 1'b0;
    end
`ifdef LPC_MAILBOX_IRQ_EN
    else if (off == 16'd2) ien = d[1:0];
    else if (off == 16'd3) ivec = d[3:0];
`endif
    @(posedge clk_i); #1; chk("wr_done_early", lpc_wr_done_o, 0);
    @(posedge clk_i); #1; chk("wr_done_latency", lpc_wr_done_o, 1);
    repeat (hold) begin @(posedge clk_i); #1; end
    lpc_data_wr_i = 1'b0;
    @(posedge clk_i); #1; chk("wr_done_drop", lpc_wr_done_o, 0);
  endtask

  task automatic host_read(input logic [15:0] a, input int hold);
    logic [15:0] off;
    logic [7:0]  e;
    logic        set_unf;
    off = a - BASE;
    set_unf = 1'b0;
    if (off == 16'd0) begin
      if (d2h_q.size() != 0) e = d2h_q.pop_front();
      else begin e = 8'h00; set_unf = 1'b1; end
    end else if (off == 16'd1)
      e = {4'b0, unf, ovf, h2d_q.size() == DEPTH, d2h_q.size() != 0};
    else if (off == 16'd2) e = {6'b0, ien};
    else if (off == 16'd3) e = {4'b0, ivec};
    else e = 8'hFF;
    if (set_unf) unf = 1'b1;
    exp_q.push_back(e);
    @(posedge clk_i); #1;
    lpc_addr_i = a; lpc_data_req_i = 1'b1;
    @(posedge clk_i); #1; chk("rd_early", lpc_data_rd_o, 0);
    @(posedge clk_i); #1; chk("rd_latency", lpc_data_rd_o, 1);
    repeat (hold) begin @(posedge clk_i); #1; end
    chk("rd_data_hold", lpc_data_o, e);
    lpc_data_req_i = 1'b0;
    @(posedge clk_i); #1; chk("rd_drop", lpc_data_rd_o, 0);
  endtask

  task automatic local_push(input logic [7:0] b);
    @(posedge clk_i); #1;
    chk("d2h_ready", d2h_ready_o, d2h_q.size() < DEPTH);
    if (d2h_q.size() < DEPTH) d2h_q.push_back(b);
    d2h_data_i = b; d2h_valid_i = 1'b1;
    @(posedge clk_i); #1;
    d2h_valid_i = 1'b0;
  endtask

  task automatic local_pop();
    @(posedge clk_i); #1;
    chk("h2d_valid", h2d_valid_o, h2d_q.size() != 0);
    h2d_ready_i = 1'b1;
    @(posedge clk_i); #1;
    h2d_ready_i = 1'b0;
  endtask

  task automatic check_irq();
    logic       ei;
    logic [3:0] en;
    @(posedge clk_i); #1;
`ifdef LPC_MAILBOX_IRQ_EN
    ei = (ien[0] && d2h_q.size() != 0) || (ien[1] && h2d_q.size() < DEPTH);
    en = ivec;
`else
    ei = 1'b0;
    en = 4'h0;
`endif
    chk("interrupt", interrupt_o, ei);
    chk("irq_num", irq_num_o, en);
  endtask

  initial begin
    #2;
    chk("rst_wr_done", lpc_wr_done_o, 0);
    chk("rst_data_rd", lpc_data_rd_o, 0);
    chk("rst_data", lpc_data_o, 0);
    chk("rst_interrupt", interrupt_o, 0);
    chk("rst_irq_num", irq_num_o, 0);
    chk("rst_h2d_valid", h2d_valid_o, 0);
    chk("rst_h2d_data", h2d_data_o, 0);
    chk("rst_d2h_ready", d2h_ready_o, 1);
    #21 nrst_i = 1'b1;

    // H2D single byte
    host_write(BASE, 8'hA5, 2);
    chk("h2d_valid_after_wr", h2d_valid_o, 1);
    chk("h2d_head_after_wr", h2d_data_o, 8'hA5);
    local_pop();
    local_pop();

    // D2H reads, one pop per transaction even with long hold
    local_push(8'h11);
    local_push(8'h22);
    host_read(BASE, 10);
    host_read(BASE, 10);
    host_read(BASE, 0);
    host_read(BASE + 16'd1, 0);          // 8'h08
    host_write(BASE + 16'd1, 8'h08, 0);
    host_read(BASE + 16'd1, 0);          // 8'h00

    // overflow: 17 writes, 17th dropped
    for (int i = 0; i < 17; i++) host_write(BASE, 8'(8'h30 + i), 0);
    host_read(BASE + 16'd1, 0);          // 8'h06
    for (int i = 0; i < 17; i++) local_pop();
    host_write(BASE + 16'd1, 8'h04, 0);

    // interrupt path
    host_write(BASE + 16'd3, 8'h0B, 0);
    host_write(BASE + 16'd2, 8'h01, 0);
    check_irq();
    local_push(8'h5C);
    check_irq();
    host_read(BASE + 16'd2, 0);
    host_read(BASE, 0);
    check_irq();

    // undecoded address
    host_read(16'h0CB0, 0);
    host_write(16'h0CB0, 8'hFF, 0);
    host_read(BASE + 16'd1, 0);
    check_irq();

    // reset during WR_ACK
    local_push(8'h99);
    @(posedge clk_i); #1;
    lpc_addr_i = BASE; lpc_data_i = 8'h5A; lpc_data_wr_i = 1'b1;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1; chk("pre_rst_done", lpc_wr_done_o, 1);
    #2 nrst_i = 1'b0;
    #1;
    chk("midrst_done", lpc_wr_done_o, 0);
    chk("midrst_h2d_valid", h2d_valid_o, 0);
    chk("midrst_d2h_ready", d2h_ready_o, 1);
    chk("midrst_interrupt", interrupt_o, 0);
    lpc_data_wr_i = 1'b0;
    h2d_q.delete(); d2h_q.delete();
    ovf = 1'b0; unf = 1'b0; ien = '0; ivec = '0;
    @(posedge clk_i); #3 nrst_i = 1'b1;
    host_write(BASE, 8'h77, 0);
    local_pop();
    host_read(BASE + 16'd1, 0);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 5))
        0: host_write(BASE, 8'($urandom), $urandom_range(0, 3));
        1: host_read(BASE, $urandom_range(0, 3));
        2: local_push(8'($urandom));
        3: local_pop();
        4: host_write(BASE + 16'($urandom_range(1, 4)), 8'($urandom), $urandom_range(0, 2));
        default: host_read(BASE + 16'($urandom_range(0, 4)), $urandom_range(0, 2));
      endcase
      check_irq();
    end

    repeat (3) @(posedge clk_i);
    #1;
    chk("exp_q_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
